// File: rtl/fpu_to_decimal.sv
// binary32 -> int32 converter with an iterative SHIFT_STEP-bit alignment shifter and valid/ready handshakes.
// Optional FTOI_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation toward zero.
module fpu_to_decimal #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_fp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_int,
    output logic        out_overflow,
    output logic        out_invalid,
    output logic        out_inexact,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, FIN, HOLD} state_t;

    localparam logic [4:0] STEP = 5'(SHIFT_STEP);

    state_t      state, state_nx;
    logic        sign_q, left_q, sticky_q;
    logic [4:0]  rem_q;
    logic [31:0] acc_q, res_q;
    logic        ovf_q, inv_q, inx_q;

    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    logic        is_nan, is_big, is_neg_min, is_small, is_special;
    logic [4:0]  n_init, k;
    logic [31:0] mag;

    assign s = in_fp[31];
    assign e = in_fp[30:23];
    assign f = in_fp[22:0];

    assign is_nan     = (e == 8'hFF) && (f != 23'd0);
    assign is_big     = (e >= 8'd158);
    assign is_neg_min = s && (e == 8'd158) && (f == 23'd0);
    assign is_small   = (e < 8'd127);
    assign is_special = is_nan || is_big || is_small;
    assign n_init     = (e >= 8'd150) ? 5'(e - 8'd150) : 5'(8'd150 - e);
    assign k          = (rem_q > STEP) ? STEP : rem_q;

`ifdef FTOI_ROUND_NEAREST_EN
    logic guard_q;
    assign mag = acc_q + {31'd0, guard_q & (sticky_q | acc_q[0])};
`else
    assign mag = acc_q;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (in_valid) state_nx = is_special ? HOLD : ((n_init != 5'd0) ? SHIFT : FIN);
            SHIFT: if (rem_q <= STEP) state_nx = FIN;
            FIN:   state_nx = HOLD;
            HOLD:  if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q   <= 1'b0;
            left_q   <= 1'b0;
            sticky_q <= 1'b0;
            rem_q    <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            inv_q    <= 1'b0;
            inx_q    <= 1'b0;
`ifdef FTOI_ROUND_NEAREST_EN
            guard_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sign_q   <= s;
                    left_q   <= (e >= 8'd150);
                    rem_q    <= n_init;
                    acc_q    <= {8'd0, 1'b1, f};
                    sticky_q <= 1'b0;
`ifdef FTOI_ROUND_NEAREST_EN
                    guard_q  <= 1'b0;
`endif
                    res_q    <= '0;
                    ovf_q    <= 1'b0;
                    inv_q    <= 1'b0;
                    inx_q    <= 1'b0;
                    if (is_nan) begin
                        res_q <= 32'h8000_0000;
                        inv_q <= 1'b1;
                    end else if (is_big) begin
                        res_q <= s ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        ovf_q <= !is_neg_min;
                    end else if (is_small) begin
`ifdef FTOI_ROUND_NEAREST_EN
                        // 0.5 < |x| < 1 rounds away to +-1; exactly 0.5 ties to even 0
                        if (e == 8'd126 && f != 23'd0) res_q <= s ? 32'hFFFF_FFFF : 32'h0000_0001;
`endif
                        inx_q <= (e != 8'd0) || (f != 23'd0);
                    end
                end
                SHIFT: begin
                    rem_q <= rem_q - k;
                    if (left_q) begin
                        acc_q <= acc_q << k;
                    end else begin
                        acc_q <= acc_q >> k;
`ifdef FTOI_ROUND_NEAREST_EN
                        // previous guard falls below the new guard bit, so it joins sticky
                        guard_q  <= acc_q[k - 5'd1];
                        sticky_q <= sticky_q | guard_q | (|(acc_q & ((32'd1 << (k - 5'd1)) - 32'd1)));
`else
                        sticky_q <= sticky_q | (|(acc_q & ((32'd1 << k) - 32'd1)));
`endif
                    end
                end
                FIN: begin
                    res_q <= sign_q ? (32'd0 - mag) : mag;
`ifdef FTOI_ROUND_NEAREST_EN
                    inx_q <= sticky_q | guard_q;
`else
                    inx_q <= sticky_q;
`endif
                    ovf_q <= 1'b0;
                    inv_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready     = (state == IDLE);
    assign busy         = (state != IDLE);
    assign out_valid    = (state == HOLD);
    assign out_int      = out_valid ? res_q : 32'd0;
    assign out_overflow = out_valid & ovf_q;
    assign out_invalid  = out_valid & inv_q;
    assign out_inexact  = out_valid & inx_q;
endmodule

// File: tb/tb_fpu_to_decimal.sv
// Directed bench for fpu_to_decimal: arithmetic reference model, per-cycle output compare, literal pins.
module tb_fpu_to_decimal;
    localparam int S = 4;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [31:0] in_fp = 32'd0, out_int;
    logic        out_overflow, out_invalid, out_inexact, busy;

    int checks = 0, errors = 0;
    logic        exp_on = 1'b0;
    logic [31:0] exp_int = 32'd0;
    logic        exp_ovf = 1'b0, exp_inv = 1'b0, exp_inx = 1'b0;
    int          exp_lat = 0;

    fpu_to_decimal #(.SHIFT_STEP(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fp(in_fp),
        .out_valid(out_valid), .out_ready(out_ready), .out_int(out_int),
        .out_overflow(out_overflow), .out_invalid(out_invalid), .out_inexact(out_inexact),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    // Reference: value = m * 2^(E-150), then integer rounding/saturation from plain arithmetic.
    function automatic void model(input logic [31:0] fp, output logic [31:0] r,
                                  output logic ov, output logic iv, output logic ix, output int lat);
        logic        sg;
        int          e, sh, n;
        logic [63:0] m, mag, rem, half;
        logic        rnd;
        sg = fp[31];
        e  = int'(fp[30:23]);
        r = 32'd0; ov = 1'b0; iv = 1'b0; ix = 1'b0; lat = 1; rnd = 1'b0;
        if (e == 255 && fp[22:0] != 23'd0) begin
            r = 32'h8000_0000; iv = 1'b1;
        end else if (e >= 158) begin
            if (sg && e == 158 && fp[22:0] == 23'd0) r = 32'h8000_0000;
            else begin r = sg ? 32'h8000_0000 : 32'h7FFF_FFFF; ov = 1'b1; end
        end else begin
            m = (e == 0) ? {41'd0, fp[22:0]} : {40'd0, 1'b1, fp[22:0]};
            if (e >= 150) begin
                mag = m << (e - 150);
                rem = 64'd0;
            end else begin
                sh = 150 - e;
                if (sh >= 40) begin
                    mag = 64'd0; rem = m;
                end else begin
                    mag  = m >> sh;
                    rem  = m & ((64'd1 << sh) - 64'd1);
                    half = 64'd1 << (sh - 1);
`ifdef FTOI_ROUND_NEAREST_EN
                    rnd = (rem > half) || (rem == half && mag[0]);
`else
                    rnd = (half == 64'd0);
`endif
                end
            end
            ix  = (rem != 64'd0);
            mag = mag + {63'd0, rnd};
            r   = sg ? (32'd0 - mag[31:0]) : mag[31:0];
            if (e >= 127) begin
                n   = (e >= 150) ? e - 150 : 150 - e;
                lat = 2 + (n + S - 1) / S;
            end
        end
    endfunction

    // Continuous output compare on every falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                chk("cmp_int", out_int, exp_int);
                chk("cmp_flags", {29'd0, out_overflow, out_invalid, out_inexact},
                    {29'd0, exp_ovf, exp_inv, exp_inx});
                chk("cmp_inrdy_hold", {31'd0, in_ready}, 32'd0);
            end else begin
                chk("cmp_flags_idle", {29'd0, out_overflow, out_invalid, out_inexact}, 32'd0);
            end
        end
    end

    task automatic conv(input logic [31:0] fp, input logic pin, input logic [31:0] lit_int,
                        input logic [2:0] lit_flags, input int lit_lat, input int hold);
        int lat;
        @(negedge clk);
        model(fp, exp_int, exp_ovf, exp_inv, exp_inx, exp_lat);
        exp_on = 1'b1;
        out_ready = (hold == 0);
        in_fp = fp; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_fp = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        chk("latency", lat, exp_lat);
        if (pin) begin
            chk("pin_int", out_int, lit_int);
            chk("pin_flags", {29'd0, out_overflow, out_invalid, out_inexact}, {29'd0, lit_flags});
            chk("pin_lat", lat, lit_lat);
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk); in_valid = 1'b1; in_fp = 32'h3F80_0000;
                @(posedge clk); #1;
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_inrdy", {31'd0, in_ready}, 32'd0);
            end
            @(negedge clk); out_ready = 1'b1; in_valid = 1'b0;
        end
        @(posedge clk); #1;
        chk("back_idle", {30'd0, out_valid, in_ready}, 32'd1);
        @(posedge clk); #1;
        chk("no_extra_accept", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #12;
        chk("reset_state", {out_int, 1'b0}, 33'd0 >> 1);
        chk("reset_ctl", {26'd0, in_ready, busy, out_valid, out_overflow, out_invalid, out_inexact},
            32'h20);
        @(negedge clk); rst = 1'b0;

        conv(32'h3F80_0000, 1'b1, 32'h0000_0001, 3'b000, 8, 0);
        conv(32'hC2F6_E979, 1'b1, 32'hFFFF_FF85, 3'b001, 7, 0);
        conv(32'h4EFF_FFFF, 1'b1, 32'h7FFF_FF80, 3'b000, 4, 0);
        conv(32'h4B7F_FFFF, 1'b1, 32'h00FF_FFFF, 3'b000, 2, 0);
        conv(32'h4F00_0000, 1'b1, 32'h7FFF_FFFF, 3'b100, 1, 0);
        conv(32'hCF00_0000, 1'b1, 32'h8000_0000, 3'b000, 1, 0);
        conv(32'h7FC0_0000, 1'b1, 32'h8000_0000, 3'b010, 1, 0);
        conv(32'hFF80_0000, 1'b1, 32'h8000_0000, 3'b100, 1, 0);
        conv(32'h3F00_0000, 1'b1, 32'h0000_0000, 3'b001, 1, 0);
        conv(32'h0000_0000, 1'b1, 32'h0000_0000, 3'b000, 1, 0);
        conv(32'hCEFF_FFFF, 1'b1, 32'h8000_0080, 3'b000, 4, 0);

        conv(32'h3FC0_0000, 1'b0, 32'd0, 3'b000, 0, 0);
        conv(32'h4020_0000, 1'b0, 32'd0, 3'b000, 0, 0);
        conv(32'hBF40_0000, 1'b0, 32'd0, 3'b000, 0, 0);
        conv(32'h3F7F_FFFF, 1'b0, 32'd0, 3'b000, 0, 0);
        conv(32'h0000_0001, 1'b0, 32'd0, 3'b000, 0, 0);
        conv(32'h4F80_0000, 1'b0, 32'd0, 3'b000, 0, 0);
        conv(32'hCF00_0001, 1'b0, 32'd0, 3'b000, 0, 0);
        conv(32'hFF80_0001, 1'b0, 32'd0, 3'b000, 0, 0);
        conv(32'h47F1_2065, 1'b0, 32'd0, 3'b000, 0, 0);
        conv(32'hC0B8_0000, 1'b0, 32'd0, 3'b000, 0, 0);

        conv(32'hC2F6_E979, 1'b1, 32'hFFFF_FF85, 3'b001, 7, 5);

        // asynchronous reset while the shifter is running
        @(negedge clk); in_fp = 32'h3F80_0000; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1; #1;
        chk("rst_mid", {29'd0, out_valid, in_ready, busy}, 32'h2);
        @(negedge clk); rst = 1'b0;
        conv(32'h4040_0000, 1'b1, 32'h0000_0003, 3'b000, 8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #90000;
        errors++;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpu_to_decimal.md
Name: fpu_to_decimal

Overview:
- Converts IEEE-754 single-precision (binary32) to a signed 32-bit two's-complement integer; the inverse path of our integer-to-float converter in the FPU test harness.
- Multi-cycle: magnitude aligned by an iterative barrel step of SHIFT_STEP bits/cycle, valid/ready on both sides.
- Default rounding: truncate toward zero; saturation and status flags per result.

Parameters:
- SHIFT_STEP, 4, bits shifted per SHIFT cycle; legal 1..31.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input float valid
- in_ready  out  1  converter can accept; high only in IDLE
- in_fp  in  32  binary32 operand {sign, exp[7:0], frac[22:0]}
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  downstream accepts result
- out_int  out  32  signed integer result
- out_overflow  out  1  magnitude out of int32 range or Inf; result saturated
- out_invalid  out  1  operand was NaN
- out_inexact  out  1  nonzero fraction bits discarded
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0 except in_ready=1.
- Terms: E=exp, m={1,frac} (24 b), value = m*2^(E-150).
- States: IDLE, SHIFT, FIN, HOLD.
- IDLE:
  - On in_valid&in_ready, classify, capture sign and go to next state.
  - Specials go directly to HOLD with result loaded:
    - NaN (E=255, frac!=0): out_int=0x80000000, invalid=1.
    - Inf, or E>=158: sign=0 gives 0x7FFFFFFF; sign=1 gives 0x80000000; overflow=1.
    - Exception to the above: sign=1, E=158, frac=0 gives 0x80000000 exactly, overflow=0.
    - E<127, incl. zero/denormal: out_int=0; inexact=(E!=0 or frac!=0).
  - Normal (127<=E<=157): acc={8'b0,m}, sticky=0. Shift direction is left when E>=150, right otherwise; n=|E-150| (0..23). Next state is SHIFT if n>0, else FIN.
- SHIFT:
  - Each cycle shift acc by k=min(SHIFT_STEP, remaining) and decrement remaining by k.
  - Right shifts OR the bits shifted out into sticky.
  - Go to FIN when remaining reaches 0.
- FIN: out_int = sign ? -acc : acc; inexact=sticky; overflow=invalid=0; go to HOLD.
- HOLD:
  - out_valid=1; out_int and flags stable until out_valid&out_ready, then go to IDLE.
  - No new accept in the same cycle (in_ready=0 in HOLD).
- Latency, in edges from the accepting edge to out_valid high:
  - Specials: L=1.
  - Normals: L=2+ceil(n/SHIFT_STEP).
- Throughput: one conversion per L+1 cycles at best.
- Flags are sampled together with out_int; all flags are 0 whenever out_valid=0.
- Normal range max magnitude: 0xFFFFFF<<7 = 0x7FFFFF80, so no overflow is possible in FIN.
- in_fp is sampled only on the accept edge; later changes are ignored.

Optional Feature:
- Macro: FTOI_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even.
  - The last bit shifted out (guard) is kept separately from sticky.
  - FIN adds 1 to acc before negation when guard&(sticky|acc[0]).
  - E=126 is handled in IDLE as a special (L=1): frac!=0 gives ±1 with inexact=1; frac=0 gives 0 with inexact=1.
  - Other E<127 cases give 0.
- Undefined: truncation only; no guard logic is synthesised.

Test Plan:
- in_fp=0x3F800000 (1.0), SHIFT_STEP=4 -> out_int=0x00000001, inexact=0, L=8 (n=23).
- in_fp=0xC2F6E979 (-123.456) -> out_int=0xFFFFFF85, inexact=1, L=7. With FTOI_ROUND_NEAREST_EN: same value.
- in_fp=0x4EFFFFFF -> out_int=0x7FFFFF80, flags 0, L=4. in_fp=0x4B7FFFFF -> out_int=0x00FFFFFF, L=2.
- Specials, each L=1:
  - 0x4F000000 -> 0x7FFFFFFF, overflow=1.
  - 0xCF000000 -> 0x80000000, overflow=0.
  - 0x7FC00000 -> 0x80000000, invalid=1.
  - 0xFF800000 -> 0x80000000, overflow=1.
  - 0x3F000000 (0.5) -> 0, inexact=1.
  - 0x00000000 -> 0, flags 0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD -> out_int and flags stable, in_ready=0, in_valid ignored. Then assert out_ready -> IDLE the next cycle.
- Reset mid-op: assert rst during SHIFT of 1.0 -> state immediately IDLE, out_valid=0, in_ready=1. A following 0x40400000 (3.0) converts cleanly to 0x00000003.
